// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit.
// Access sizes, FSM states and lane-select helpers.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  localparam logic [31:0] LANE_B = 32'h0000_00ff;
  localparam logic [31:0] LANE_H = 32'h0000_ffff;
  localparam logic [31:0] LANE_W = 32'hffff_ffff;

  // Bytes touched by an access; reserved reports 4 so the
  // range check still has a defined value (it faults anyway).
  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    logic [2:0] n;
    n = 3'd4;
    if (sz == SZ_BYTE) n = 3'd1;
    if (sz == SZ_HALF) n = 3'd2;
    return n;
  endfunction

  // Byte-enable style mask of the lanes an access covers.
  function automatic logic [31:0] lane_mask(
    input logic [1:0] sz,
    input logic [1:0] off
  );
    logic [31:0] m;
    m = LANE_W;
    if (sz == SZ_BYTE) m = LANE_B << {off, 3'b000};
    if (sz == SZ_HALF) m = LANE_H << {off[1], 4'b0000};
    return m;
  endfunction

endpackage

// File: rtl/mem_access_unit_align.sv
// Lane extract/extend for loads and lane merge for stores.
// In: size/offset/unsigned, memory word, store data. Out: load data, merged word.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ldata_o,
  output logic [31:0] mword_o
);

  logic [31:0] shb;
  logic [31:0] shh;
  logic [31:0] rep;
  logic [31:0] mask;

  assign shb  = rword_i >> {off_i, 3'b000};
  assign shh  = rword_i >> {off_i[1], 4'b0000};
  assign mask = lane_mask(size_i, off_i);

  always_comb begin
    ldata_o = '0;
    rep     = wdata_i;
    unique case (size_i)
      SZ_BYTE: begin
        ldata_o = unsigned_i ? {24'h0, shb[7:0]}
                             : {{24{shb[7]}}, shb[7:0]};
        rep     = {4{wdata_i[7:0]}};
      end
      SZ_HALF: begin
        ldata_o = unsigned_i ? {16'h0, shh[15:0]}
                             : {{16{shh[15]}}, shh[15:0]};
        rep     = {2{wdata_i[15:0]}};
      end
      SZ_WORD: ldata_o = rword_i;
      SZ_RSVD: ldata_o = '0;
    endcase
  end

  // Replicated store data lands in every lane; mask keeps the target.
  assign mword_o = (rword_i & ~mask) | (rep & mask);

endmodule

// File: rtl/mem_access_unit.sv
// Sub-word load/store adapter in front of a word-wide data memory.
// Ports: MEM-stage request in, extended load data / stall / fault out,
// word-aligned memory strobes out, combinational memory read data in.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        fault_o,
  output logic [31:0] fault_addr_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i
);

  state_e      state_q, state_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic [31:0] abuf_q, abuf_d;
  logic        fault_q, fault_d;
  logic [31:0] faddr_q, faddr_d;

  logic [31:0] ldata;
  logic [31:0] mword;
  logic [31:0] al;
  logic [32:0] last;
  logic        oor;
  logic        bad;
  logic        req;

  mem_lane_align u_align (
    .size_i     (size_i),
    .off_i      (addr_i[1:0]),
    .unsigned_i (unsigned_i),
    .rword_i    (mem_rdata_i),
    .wdata_i    (wdata_i),
    .ldata_o    (ldata),
    .mword_o    (mword)
  );

  assign req  = MemRead_i | MemWrite_i;
  assign al   = {addr_i[31:2], 2'b00};
  // 33 bits so an address near 2^32 cannot wrap into range.
  assign last = {1'b0, addr_i}
              + {30'h0, size_bytes(size_i)} - 33'd1;
  assign oor  = last >= 33'(MEM_BYTES);
  assign bad  = (size_i == SZ_RSVD)
              | ((size_i == SZ_HALF) & addr_i[0])
              | ((size_i == SZ_WORD) & (|addr_i[1:0]))
              | oor;

  always_comb begin
    state_d     = state_q;
    wbuf_d      = wbuf_q;
    abuf_d      = abuf_q;
    fault_d     = fault_q;
    faddr_d     = faddr_q;
    rdata_o     = '0;
    stall_o     = 1'b0;
    misalign_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req && bad) begin
          misalign_o = 1'b1;
          if (!fault_q) begin
            fault_d = 1'b1;
            faddr_d = addr_i;
          end
        end else if (MemWrite_i) begin
          mem_addr_o = al;
          if (size_i == SZ_WORD) begin
            mem_write_o = 1'b1;
            mem_wdata_o = wdata_i;
          end else begin
            mem_read_o = 1'b1;
            stall_o    = 1'b1;
            wbuf_d     = mword;
            abuf_d     = al;
            state_d    = RMW_WR;
          end
        end else if (MemRead_i) begin
          mem_read_o = 1'b1;
          mem_addr_o = al;
          rdata_o    = ldata;
        end
      end
      RMW_WR: begin
        mem_write_o = 1'b1;
        mem_addr_o  = abuf_q;
        mem_wdata_o = wbuf_q;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      wbuf_q  <= '0;
      abuf_q  <= '0;
      fault_q <= 1'b0;
      faddr_q <= '0;
    end else begin
      state_q <= state_d;
      wbuf_q  <= wbuf_d;
      abuf_q  <= abuf_d;
      fault_q <= fault_d;
      faddr_q <= faddr_d;
    end
  end

  assign fault_o      = fault_q;
  assign fault_addr_o = faddr_q;

endmodule
